serial_add_sub: RTL and testbench

Bit-serial two's-complement adder/subtractor for the adder/subtractor chain. It consumes one operand bit pair per clock through a single 1-bit full-adder cell and a carry flip-flop. A WIDTH-bit result, carry-out and signed overflow are available after WIDTH processing cycles. It trades latency for area compared with the parallel combinational adders, and feeds any downstream consumer through a start/done handshake.

---
 rtl/serial_add_sub_pkg.sv | 13 +
 rtl/serial_add_sub_if.sv | 24 ++
 rtl/serial_add_sub_fa_cell.sv | 18 +
 rtl/serial_add_sub.sv | 122 ++++++++++++
 tb/tb_serial_add_sub.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_if.sv
// Start/done handshake and operand/result bus of the serial adder/subtractor.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_add_sub_fa_cell.sv
// 1-bit full adder built from two half-adder stages and an OR of their carries.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s1;
  logic c1;
  logic c2;

  assign s1   = x ^ y;
  assign c1   = x & y;
  assign s    = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one bit pair per clock, LSB first,
// through a single full-adder cell and carry flop. Result valid with the done pulse.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit per cycle, counter 0..WIDTH-1
// DONE  | done pulse; start here is accepted back-to-back
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_add_sub_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d;
  logic               cmsb_q, cmsb_d;
  logic               co_q, co_d;
  logic               ov_q, ov_d;

  logic               accept;
  logic               fa_s;
  logic               fa_cout;

  serial_fa_cell u_fa (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // start is only looked at outside RUN, so DONE behaves like IDLE for acceptance
  assign accept = bus.start && (state_q != RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cmsb_q  <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cmsb_q  <= cmsb_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    c_d    = c_q;
    cmsb_d = cmsb_q;
    co_d   = co_q;
    ov_d   = ov_q;
    if (accept) begin
      // subtraction is a + ~b + 1: invert b here and seed the carry with 1
      a_d    = bus.a;
      b_d    = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
      c_d    = (bus.sub == OP_SUB);
      res_d  = '0;
      cnt_d  = '0;
      cmsb_d = 1'b0;
      co_d   = 1'b0;
      ov_d   = 1'b0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = {fa_s, res_q[WIDTH-1:1]};
      c_d   = fa_cout;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_PRE) cmsb_d = fa_cout;
      if (cnt_q == CNT_LAST) begin
        co_d = fa_cout;
        ov_d = cmsb_q ^ fa_cout;
      end
    end
  end

  always_comb begin
    bus.busy      = (state_q == RUN);
    bus.done      = (state_q == DONE);
    bus.result    = res_q;
    bus.carry_out = co_q;
    bus.overflow  = ov_q;
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub with a result scoreboard checked on every done pulse.
module tb_serial_add_sub;
  import add_sub_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(W)) bus ();

  serial_add_sub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   bad    = 0;
  int   n_done = 0;

  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   full;
    logic [W-1:0] bb;
    exp_t         e;
    bb    = s ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
    e.res = full[W-1:0];
    e.co  = full[W];
    e.ov  = (a[W-1] == bb[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      n_done++;
      check("sb_nonempty_at_done", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", 32'(bus.result), 32'(e.res));
        check("carry_out", 32'(bus.carry_out), 32'(e.co));
        check("overflow", 32'(bus.overflow), 32'(e.ov));
      end
    end
  end

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.a     = a;
    bus.b     = b;
    if (push) sb.push_back(model(s, a, b));
  endtask

  // counts negedges until done is seen (first step always taken)
  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.done !== 1'b1 && k < 30);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int   k;
    exp_t e;
    e = model(s, a, b);
    @(negedge clk);
    drive(s, a, b, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(k);
    check({tag, "_latency"}, 32'(k + 1), 32'(W + 1));
    @(negedge clk);
    check({tag, "_done_single"}, 32'(bus.done), 32'd0);
    check({tag, "_hold"}, 32'(bus.result), 32'(e.res));
  endtask

  initial begin
    int k;
    int nd;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = OP_ADD;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_co", 32'(bus.carry_out), 32'd0);
    check("rst_ov", 32'(bus.overflow), 32'd0);
    rst = 1'b0;

    run_op("add35_4a", OP_ADD, 8'h35, 8'h4A);
    run_op("addff_01", OP_ADD, 8'hFF, 8'h01);
    run_op("add7f_01", OP_ADD, 8'h7F, 8'h01);
    run_op("sub10_20", OP_SUB, 8'h10, 8'h20);
    run_op("sub80_01", OP_SUB, 8'h80, 8'h01);
    run_op("sub00_00", OP_SUB, 8'h00, 8'h00);
    run_op("add80_80", OP_ADD, 8'h80, 8'h80);
    for (int i = 0; i < 6; i++)
      run_op("rand", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

    // start during RUN must be ignored
    nd = n_done;
    @(negedge clk);
    drive(OP_ADD, 8'h12, 8'h34, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'hAA;
    repeat (2) @(negedge clk);
    drive(OP_SUB, 8'h55, 8'h66, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k);
    check("ignore_latency", 32'(k + 4), 32'(W + 1));
    repeat (12) @(negedge clk);
    check("ignore_done_count", 32'(n_done - nd), 32'd1);

    // start held high: back-to-back, done every W+1 cycles
    @(negedge clk);
    drive(OP_ADD, 8'h01, 8'h02, 1'b1);
    wait_done(k);
    check("b2b_first", 32'(k), 32'(W + 1));
    drive(OP_SUB, 8'h03, 8'h05, 1'b1);
    wait_done(k);
    check("b2b_interval1", 32'(k), 32'(W + 1));
    drive(OP_ADD, 8'hC0, 8'hC0, 1'b1);
    wait_done(k);
    check("b2b_interval2", 32'(k), 32'(W + 1));
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b_idle_busy", 32'(bus.busy), 32'd0);

    // reset in the middle of RUN aborts without done
    @(negedge clk);
    drive(OP_ADD, 8'h77, 8'h11, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    nd  = n_done;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(n_done - nd), 32'd0);
    run_op("after_abort", OP_SUB, 8'h7F, 8'hFF);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
